vote_session_ctrl: RTL and testbench

Sequential controller that runs a 4-voter ballot session around the team's 3-of-4 majority voter function. It opens a session on `start` and collects one vote per voter through per-voter strobes. It closes the session when all four voters have voted or a timeout expires, then reports pass/fail (pass = at least 3 yes votes) with a one-cycle `done` pulse. It sits between the voter inputs and whatever consumes the decision, and it sequences the voting datapath.

---
 rtl/vote_session_ctrl.sv | 130 +++++++++++++
 tb/tb_vote_session_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// Ballot session controller for four voters around a 3-of-4 majority decision.
// Each voter lane records its first vote; the FSM handles open, timeout and decide.

module vote_session_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic vld,
  input  logic val,
  output logic voted,
  output logic voted_nxt,
  output logic yes_nxt
);
  logic ballot;
  logic take;

  // The first strobe in a session is final; later strobes from this voter are dropped.
  assign take      = en & vld & ~voted;
  assign voted_nxt = voted | take;
  assign yes_nxt   = take ? val : ballot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted  <= 1'b0;
      ballot <= 1'b0;
    end else if (clr) begin
      voted  <= 1'b0;
      ballot <= 1'b0;
    end else if (take) begin
      voted  <= 1'b1;
      ballot <= val;
    end
  end
endmodule

module vote_session_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  output logic       busy,
  output logic [3:0] voted,
  output logic [2:0] yes_cnt,
  output logic       done,
  output logic       pass,
  output logic       timed_out
);
  localparam int NUM_LANES = 4;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE} state_t;

  state_t               state;
  logic [7:0]           timer;
  logic [NUM_LANES-1:0] voted_nxt;
  logic [NUM_LANES-1:0] yes_nxt;
  logic [2:0]           yes_sum;
  logic                 open_sess;
  logic                 collecting;

  assign open_sess  = (state == IDLE) && start;
  assign collecting = (state == COLLECT);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vote_session_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (open_sess),
      .en        (collecting),
      .vld       (vote_valid[i]),
      .val       (vote_val[i]),
      .voted     (voted[i]),
      .voted_nxt (voted_nxt[i]),
      .yes_nxt   (yes_nxt[i])
    );
  end

  always_comb begin
    yes_sum = 3'd0;
    for (int i = 0; i < NUM_LANES; i++)
      yes_sum = yes_sum + 3'(yes_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= 8'd0;
      busy      <= 1'b0;
      yes_cnt   <= 3'd0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= COLLECT;
          busy      <= 1'b1;
          timer     <= 8'd0;
          yes_cnt   <= 3'd0;
          pass      <= 1'b0;
          timed_out <= 1'b0;
        end
        COLLECT: begin
          yes_cnt <= yes_sum;
          timer   <= timer + 8'd1;
          // A completed vote set beats the timer on the same edge.
          if (&voted_nxt) begin
            state     <= DECIDE;
            timed_out <= 1'b0;
          end else if (timer == LAST) begin
            state     <= DECIDE;
            timed_out <= 1'b1;
          end
        end
        DECIDE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (yes_cnt >= 3'd3);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed and randomized ballot sessions checked against a per-session plan model.
module tb_vote_session_ctrl;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] vote_valid = 4'd0;
  logic [3:0] vote_val = 4'd0;
  logic       busy;
  logic [3:0] voted;
  logic [2:0] yes_cnt;
  logic       done, pass, timed_out;

  int checks = 0;
  int errors = 0;

  // Stimulus plan, indexed by edge number within a session (edge 0 samples start).
  logic [3:0] vv [0:T+1];
  logic [3:0] vl [0:T+1];

  always #5 clk = ~clk;

  vote_session_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_val(vote_val),
    .busy(busy), .voted(voted), .yes_cnt(yes_cnt), .done(done), .pass(pass), .timed_out(timed_out)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 8'(busy), 8'd0);
    check({tag, ".voted"}, 8'(voted), 8'd0);
    check({tag, ".yes_cnt"}, 8'(yes_cnt), 8'd0);
    check({tag, ".done"}, 8'(done), 8'd0);
    check({tag, ".pass"}, 8'(pass), 8'd0);
    check({tag, ".timed_out"}, 8'(timed_out), 8'd0);
  endtask

  task automatic clear_plan();
    for (int k = 0; k <= T + 1; k++) begin
      vv[k] = 4'd0;
      vl[k] = 4'($urandom);
    end
  endtask

  task automatic put(input int k, input logic [3:0] m, input logic [3:0] v);
    vv[k] = vv[k] | m;
    vl[k] = (vl[k] & ~m) | (v & m);
  endtask

  task automatic rand_plan(input int density);
    for (int k = 0; k <= T + 1; k++) begin
      for (int i = 0; i < 4; i++) vv[k][i] = ($urandom_range(1, density) == 1);
      vl[k] = 4'($urandom);
    end
  endtask

  // Session outcome from the plan: each voter's first strobe in edges 1..T counts;
  // the session closes when the fourth voter lands or at edge T, done one edge later.
  task automatic run_session(input string tag, input int gap, input bit noisy_start);
    int f [4];
    int close, ee, ye;
    bit all;
    logic [3:0] vexp;
    all = 1'b1;
    close = 0;
    for (int i = 0; i < 4; i++) begin
      f[i] = 0;
      for (int k = 1; k <= T; k++)
        if (f[i] == 0 && vv[k][i]) f[i] = k;
      if (f[i] == 0) all = 1'b0;
      if (f[i] > close) close = f[i];
    end
    if (!all) close = T;

    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      start = 1'b0;
      vote_valid = 4'($urandom);
      vote_val = 4'($urandom);
      @(posedge clk); #1;
      check({tag, ".idle_busy"}, 8'(busy), 8'd0);
      check({tag, ".idle_done"}, 8'(done), 8'd0);
    end

    for (int e = 0; e <= close + 1; e++) begin
      @(negedge clk);
      start = (e == 0) ? 1'b1 : (noisy_start ? 1'($urandom_range(0, 1)) : 1'b0);
      vote_valid = vv[e];
      vote_val = vl[e];
      @(posedge clk); #1;
      ee = (e < close) ? e : close;
      ye = 0;
      vexp = 4'd0;
      for (int i = 0; i < 4; i++)
        if (f[i] > 0 && f[i] <= ee) begin
          vexp[i] = 1'b1;
          if (vl[f[i]][i]) ye++;
        end
      check({tag, ".busy"}, 8'(busy), 8'(e <= close));
      check({tag, ".done"}, 8'(done), 8'(e == close + 1));
      check({tag, ".voted"}, 8'(voted), 8'(vexp));
      check({tag, ".yes_cnt"}, 8'(yes_cnt), 8'(ye));
      check({tag, ".pass"}, 8'(pass), 8'((e == close + 1) && ye >= 3));
      check({tag, ".timed_out"}, 8'(timed_out), 8'((e >= close) && !all));
    end
  endtask

  initial begin
    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Mid-COLLECT asynchronous reset with two votes accepted
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; vote_valid = 4'b0011; vote_val = 4'b0001; end
    @(posedge clk); #1;
    check("pre_rst.voted", 8'(voted), 8'h03);
    check("pre_rst.yes_cnt", 8'(yes_cnt), 8'd1);
    check("pre_rst.busy", 8'(busy), 8'd1);
    @(negedge clk) vote_valid = 4'd0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst.busy", 8'(busy), 8'd0);

    // Unanimous
    clear_plan(); put(1, 4'b1111, 4'b1111);
    run_session("unanimous", 0, 1'b0);

    // Staggered 3-of-4, started in the previous done cycle
    clear_plan();
    put(1, 4'b0001, 4'b0001); put(2, 4'b0100, 4'b0000);
    put(3, 4'b0010, 4'b0010); put(4, 4'b1000, 4'b1000);
    run_session("stagger", 0, 1'b0);

    // Timeout fail: only v0, v1 yes
    clear_plan(); put(2, 4'b0001, 4'b0001); put(5, 4'b0010, 4'b0010);
    run_session("timeout", 1, 1'b0);

    // Boundary: three yes, v3 silent
    clear_plan(); put(3, 4'b0111, 4'b0111);
    run_session("bound_to", 0, 1'b0);

    // Variant: v3 lands exactly on the expiry edge
    clear_plan(); put(3, 4'b0111, 4'b0111); put(T, 4'b1000, 4'b0000);
    run_session("bound_last", 0, 1'b0);

    // Duplicate strobe with the opposite value, plus start pulses while busy
    clear_plan();
    put(1, 4'b0001, 4'b0001); put(3, 4'b0001, 4'b0000);
    put(2, 4'b0010, 4'b0010); put(5, 4'b1100, 4'b0100);
    run_session("dup", 0, 1'b1);

    // Randomized sessions
    for (int s = 0; s < 30; s++) begin
      rand_plan($urandom_range(2, 14));
      run_session("rand", $urandom_range(0, 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
